// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, state codes,
// ALU/mux select values and the bundled control-word type.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       irWrite;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
    } ctrl_t;

    // States that own the memory port and therefore run the wait counter.
    function automatic logic isMemState(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Memory-wait counter: counts stalled cycles in a memory state and flags when
// WAIT_MAX stalls have already elapsed.
module mc_wait_cnt #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (inc)
            cnt <= cnt + 8'd1;
    end

    assign expired = (cnt == 8'(WAIT_MAX));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller (R/LW/SW/BEQ/J) with memory-ready timeout.
// Define MC_CTRL_ADDI_EN to add ADDI decode (ADDIEX/ADDIWB states).
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    logic [3:0] stateQ, stateNext;
    logic [5:0] opQ;
    logic       inMem, cntExpired, timeout, illegalDec;
    logic       cntClr, cntInc;
    ctrl_t      ctrl;

    assign inMem   = isMemState(stateQ);
    assign timeout = inMem && !mem_ready && cntExpired;

    // FETCH can time out back into FETCH, so a timeout clears even without a state change.
    assign cntClr = !inMem || (stateNext != stateQ) || timeout;
    assign cntInc = !mem_ready;

    mc_wait_cnt #(.WAIT_MAX(WAIT_MAX)) uWaitCnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cntClr),
        .inc     (cntInc),
        .expired (cntExpired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= S_FETCH;
            opQ    <= OP_R;
        end else begin
            stateQ <= stateNext;
            if (stateQ == S_DECODE)
                opQ <= op;
        end
    end

    always_comb begin
        stateNext  = S_FETCH;
        illegalDec = 1'b0;
        case (stateQ)
            S_FETCH:  stateNext = (mem_ready && !timeout) ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: stateNext = S_MEMADR;
                    OP_R:         stateNext = S_EXEC;
                    OP_BEQ:       stateNext = S_BRANCH;
                    OP_J:         stateNext = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      stateNext = S_ADDIEX;
`endif
                    default: begin
                        stateNext  = S_FETCH;
                        illegalDec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: stateNext = (opQ == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (timeout)        stateNext = S_FETCH;
                else if (mem_ready) stateNext = S_MEMWB;
                else                stateNext = S_MEMRD;
            end
            S_MEMWR:  stateNext = (mem_ready || timeout) ? S_FETCH : S_MEMWR;
            S_EXEC:   stateNext = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: stateNext = S_ADDIWB;
`endif
            default:  stateNext = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (stateQ)
            S_FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALU_ADD;
                ctrl.pcSource = PCS_ALU;
                ctrl.irWrite  = mem_ready;
                ctrl.pcWrite  = mem_ready;
            end
            S_DECODE: begin
                ctrl.aluSrcB = SRCB_IMMSH;
                ctrl.aluOp   = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            S_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_RT;
                ctrl.aluOp       = ALU_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCS_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCS_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            S_ADDIWB: ctrl.regWrite = 1'b1;
`endif
            default: ctrl = '0;
        endcase
        // A timed-out FETCH must not capture a stale IR or bump the PC.
        if (timeout) begin
            ctrl.irWrite  = 1'b0;
            ctrl.pcWrite  = 1'b0;
            ctrl.regWrite = 1'b0;
        end
        if (rst)
            ctrl = '0;
    end

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign IRWrite     = ctrl.irWrite;
    assign PCSource    = ctrl.pcSource;
    assign ALUOp       = ctrl.aluOp;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign RegWrite    = ctrl.regWrite;
    assign RegDst      = ctrl.regDst;
    assign illegal_op  = !rst && illegalDec;
    assign mem_timeout = !rst && timeout;
    assign state       = rst ? S_FETCH : stateQ;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm (WAIT_MAX=4), plus a hand-written
// asynchronous-reset-during-MEMRD sequence.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, illegal_op, mem_timeout;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    // Order: PW PWC IorD MR MW M2R IRW | PCS | AOP | ASA | ASB | RW RD ILL TO
    localparam logic [17:0] O_RST  = 18'b0000000_00_00_0_00_0000;
    localparam logic [17:0] O_F0   = 18'b0001000_00_00_0_01_0000;
    localparam logic [17:0] O_F1   = 18'b1001001_00_00_0_01_0000;
    localparam logic [17:0] O_DEC  = 18'b0000000_00_00_0_11_0000;
    localparam logic [17:0] O_DILL = 18'b0000000_00_00_0_11_0010;
    localparam logic [17:0] O_MADR = 18'b0000000_00_00_1_10_0000;
    localparam logic [17:0] O_MRD  = 18'b0011000_00_00_0_00_0000;
    localparam logic [17:0] O_MWB  = 18'b0000010_00_00_0_00_1000;
    localparam logic [17:0] O_MWR  = 18'b0010100_00_00_0_00_0000;
    localparam logic [17:0] O_MWTO = 18'b0010100_00_00_0_00_0001;
    localparam logic [17:0] O_EXE  = 18'b0000000_00_10_1_00_0000;
    localparam logic [17:0] O_AWB  = 18'b0000000_00_00_0_00_1100;
    localparam logic [17:0] O_BR   = 18'b0100000_01_01_1_00_0000;
    localparam logic [17:0] O_JMP  = 18'b1000000_10_00_0_00_0000;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BADOP = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  expState;
        logic [17:0] expOut;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic d,
                                input logic [3:0] s, input logic [17:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = d; v.expState = s; v.expOut = e;
        return v;
    endfunction

    function automatic logic [17:0] outs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op, mem_timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        vq.push_back(mk(1, R,     1, 4'd0, O_RST));
        // R-type
        vq.push_back(mk(0, R,     1, 4'd0, O_F1));
        vq.push_back(mk(0, R,     1, 4'd1, O_DEC));
        vq.push_back(mk(0, R,     1, 4'd6, O_EXE));
        vq.push_back(mk(0, R,     1, 4'd7, O_AWB));
        // LW with 3 stall cycles in MEMRD
        vq.push_back(mk(0, LW,    1, 4'd0, O_F1));
        vq.push_back(mk(0, LW,    1, 4'd1, O_DEC));
        vq.push_back(mk(0, LW,    1, 4'd2, O_MADR));
        vq.push_back(mk(0, LW,    0, 4'd3, O_MRD));
        vq.push_back(mk(0, LW,    0, 4'd3, O_MRD));
        vq.push_back(mk(0, LW,    0, 4'd3, O_MRD));
        vq.push_back(mk(0, LW,    1, 4'd3, O_MRD));
        vq.push_back(mk(0, LW,    1, 4'd4, O_MWB));
        // BEQ, then FETCH stalled
        vq.push_back(mk(0, BEQ,   1, 4'd0, O_F1));
        vq.push_back(mk(0, BEQ,   1, 4'd1, O_DEC));
        vq.push_back(mk(0, BEQ,   1, 4'd8, O_BR));
        vq.push_back(mk(0, BEQ,   0, 4'd0, O_F0));
        // Illegal opcode
        vq.push_back(mk(0, BADOP, 1, 4'd0, O_F1));
        vq.push_back(mk(0, BADOP, 1, 4'd1, O_DILL));
        vq.push_back(mk(0, BADOP, 0, 4'd0, O_F0));
        // ADDI is illegal in the default build
        vq.push_back(mk(0, ADDI,  1, 4'd0, O_F1));
        vq.push_back(mk(0, ADDI,  1, 4'd1, O_DILL));
        vq.push_back(mk(0, ADDI,  0, 4'd0, O_F0));
        // Jump
        vq.push_back(mk(0, J,     1, 4'd0, O_F1));
        vq.push_back(mk(0, J,     1, 4'd1, O_DEC));
        vq.push_back(mk(0, J,     1, 4'd9, O_JMP));
        // SW, immediate ready
        vq.push_back(mk(0, SW,    1, 4'd0, O_F1));
        vq.push_back(mk(0, SW,    1, 4'd1, O_DEC));
        vq.push_back(mk(0, SW,    1, 4'd2, O_MADR));
        vq.push_back(mk(0, SW,    1, 4'd5, O_MWR));
        // SW timeout: 4 stalls counted, 5th cycle expires
        vq.push_back(mk(0, SW,    1, 4'd0, O_F1));
        vq.push_back(mk(0, SW,    1, 4'd1, O_DEC));
        vq.push_back(mk(0, SW,    0, 4'd2, O_MADR));
        vq.push_back(mk(0, SW,    0, 4'd5, O_MWR));
        vq.push_back(mk(0, SW,    0, 4'd5, O_MWR));
        vq.push_back(mk(0, SW,    0, 4'd5, O_MWR));
        vq.push_back(mk(0, SW,    0, 4'd5, O_MWR));
        vq.push_back(mk(0, SW,    0, 4'd5, O_MWTO));
        vq.push_back(mk(0, SW,    0, 4'd0, O_F0));
        vq.push_back(mk(0, SW,    1, 4'd0, O_F1));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; op = vq[i].op; mem_ready = vq[i].rdy;
            #1;
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vq[i].expState));
            chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(vq[i].expOut));
        end

        // Async reset in the middle of a stalled LW
        @(negedge clk); op = LW; mem_ready = 1'b1;
        #1 chk("ar fetch", 32'(state), 32'd1);
        @(negedge clk);
        #1 chk("ar madr", 32'(state), 32'd2);
        @(negedge clk); mem_ready = 1'b0;
        #1 chk("ar memrd", 32'(state), 32'd3);
        chk("ar memrd outs", 32'(outs()), 32'(O_MRD));
        #1 rst = 1'b1;
        #1 chk("ar rst state", 32'(state), 32'd0);
        chk("ar rst outs", 32'(outs()), 32'(O_RST));
        @(negedge clk);
        #1 chk("ar held outs", 32'(outs()), 32'(O_RST));
        @(negedge clk); rst = 1'b0;
        #1 chk("ar release state", 32'(state), 32'd0);
        chk("ar release outs", 32'(outs()), 32'(O_F0));
        @(negedge clk); mem_ready = 1'b1;
        #1 chk("ar refetch outs", 32'(outs()), 32'(O_F1));
        @(negedge clk);
        #1 chk("ar redecode", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
